// File: rtl/insn_encoder.sv
// RV32I program loader: packs decoded instruction fields into machine words and
// streams them into instruction memory, flagging illegal or out-of-range bundles.
module insn_encoder #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_vld,
  output logic                o_rdy,
  input  logic                i_last,
  input  logic [3:0]          i_cls,
  input  logic [3:0]          i_alu_op,
  input  logic [2:0]          i_f3,
  input  logic [4:0]          i_rd,
  input  logic [4:0]          i_rs1,
  input  logic [4:0]          i_rs2,
  input  logic [31:0]         i_imm,
  output logic                o_imem_wren,
  output logic [ADDR_W-1:0]   o_imem_addr,
  output logic [31:0]         o_imem_wdata,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err,
  output logic [1:0]          o_err_code,
  output logic [ADDR_W:0]     o_count
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   ptr_q, ptr_d;
  logic               wren_q, wren_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [1:0]         err_code_q, err_code_d;

  logic               rdy;
  logic               accept;
  logic [2:0]         alu_f3;
  logic               alu_alt;
  logic               shift_op;
  logic [6:0]         f7;
  logic               field_bad;
  logic               imm_bad;
  logic               ovf;
  logic [1:0]         bad_code;
  logic [31:0]        word;
  logic signed [31:0] simm;
  logic               imm12_bad;
  logic               imm13_bad;
  logic               imm21_bad;

  assign simm      = i_imm;
  assign imm12_bad = (simm < -32'sd2048) || (simm > 32'sd2047);
  assign imm13_bad = (simm < -32'sd4096) || (simm > 32'sd4094) || i_imm[0];
  assign imm21_bad = (simm < -32'sd1048576) || (simm > 32'sd1048574) || i_imm[0];
  assign ovf       = (ptr_q == CNT_W'(DEPTH));
  assign accept    = rdy && i_vld;

  // Field validation and RV32I word packing for the presented bundle.
  always_comb begin : encode
    alu_f3    = 3'b000;
    alu_alt   = 1'b0;
    shift_op  = 1'b0;
    field_bad = 1'b0;
    imm_bad   = 1'b0;
    word      = '0;
    case (i_alu_op)
      4'd1:    alu_alt = 1'b1;
      4'd2:    alu_f3  = 3'b010;
      4'd3:    alu_f3  = 3'b011;
      4'd4:    alu_f3  = 3'b100;
      4'd5:    alu_f3  = 3'b110;
      4'd6:    alu_f3  = 3'b111;
      4'd7:    begin alu_f3 = 3'b001; shift_op = 1'b1; end
      4'd8:    begin alu_f3 = 3'b101; shift_op = 1'b1; end
      4'd9:    begin alu_f3 = 3'b101; shift_op = 1'b1; alu_alt = 1'b1; end
      default: ;
    endcase
    f7 = alu_alt ? 7'b0100000 : 7'b0000000;
    case (i_cls)
      4'd0: begin
        field_bad = (i_alu_op > 4'd9);
        word      = {f7, i_rs2, i_rs1, alu_f3, i_rd, OP_R};
      end
      4'd1: begin
        field_bad = (i_alu_op == 4'd1) || (i_alu_op > 4'd9);
        if (shift_op) begin
          imm_bad = |i_imm[31:5];
          word    = {f7, i_imm[4:0], i_rs1, alu_f3, i_rd, OP_IMM};
        end else begin
          imm_bad = imm12_bad;
          word    = {i_imm[11:0], i_rs1, alu_f3, i_rd, OP_IMM};
        end
      end
      4'd2: begin
        field_bad = !((i_f3 == 3'd0) || (i_f3 == 3'd1) || (i_f3 == 3'd2) ||
                      (i_f3 == 3'd4) || (i_f3 == 3'd5));
        imm_bad   = imm12_bad;
        word      = {i_imm[11:0], i_rs1, i_f3, i_rd, OP_LD};
      end
      4'd3: begin
        field_bad = (i_f3 > 3'd2);
        imm_bad   = imm12_bad;
        word      = {i_imm[11:5], i_rs2, i_rs1, i_f3, i_imm[4:0], OP_ST};
      end
      4'd4: begin
        field_bad = (i_f3 == 3'd2) || (i_f3 == 3'd3);
        imm_bad   = imm13_bad;
        word      = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_f3, i_imm[4:1], i_imm[11], OP_BR};
      end
      4'd5: begin
        imm_bad = imm21_bad;
        word    = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OP_JAL};
      end
      4'd6: begin
        imm_bad = imm12_bad;
        word    = {i_imm[11:0], i_rs1, 3'b000, i_rd, OP_JALR};
      end
      4'd7:    word = {i_imm[31:12], i_rd, OP_LUI};
      4'd8:    word = {i_imm[31:12], i_rd, OP_AUIPC};
      default: field_bad = 1'b1;
    endcase
    // Field errors outrank immediate errors, which outrank overflow.
    if (field_bad)    bad_code = 2'd1;
    else if (imm_bad) bad_code = 2'd2;
    else if (ovf)     bad_code = 2'd3;
    else              bad_code = 2'd0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin : state_reg
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    if (i_start) begin
      state_d = S_LOAD;
    end else if (state_q == S_LOAD && accept) begin
      if (bad_code != 2'd0) state_d = S_ERR;
      else if (i_last)      state_d = S_DONE;
    end
  end

  always_comb begin : state_outputs
    rdy    = (state_q == S_LOAD) && !i_start;
    o_busy = (state_q == S_LOAD);
    o_done = (state_q == S_DONE);
    o_err  = (state_q == S_ERR);
  end

  // Write pipeline: one registered write per legal accept.
  always_comb begin : datapath
    ptr_d      = ptr_q;
    wren_d     = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_code_d = err_code_q;
    if (i_start) begin
      ptr_d      = '0;
      err_code_d = 2'd0;
    end else if (accept) begin
      if (bad_code != 2'd0) begin
        err_code_d = bad_code;
      end else begin
        wren_d  = 1'b1;
        addr_d  = ptr_q[ADDR_W-1:0];
        wdata_d = word;
        ptr_d   = ptr_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin : datapath_reg
    if (!i_rst_n) begin
      ptr_q      <= '0;
      wren_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_code_q <= 2'd0;
    end else begin
      ptr_q      <= ptr_d;
      wren_q     <= wren_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_code_q <= err_code_d;
    end
  end

  assign o_rdy        = rdy;
  assign o_imem_wren  = wren_q;
  assign o_imem_addr  = addr_q;
  assign o_imem_wdata = wdata_q;
  assign o_err_code   = err_code_q;
  assign o_count      = ptr_q;

endmodule

// File: tb/tb_insn_encoder.sv
// Bench for insn_encoder: directed program cases plus randomized bundles checked
// against an arithmetic encoding model; a DEPTH=4 instance covers overflow.
module tb_insn_encoder;

  typedef struct {
    int          cls;
    int          alu;
    int          f3;
    int          rd;
    int          rs1;
    int          rs2;
    logic [31:0] imm;
    bit          last;
  } bundle_t;

  localparam int OPC [9]    = '{'h33, 'h13, 'h03, 'h23, 'h63, 'h6F, 'h67, 'h37, 'h17};
  localparam int ALU_F3 [10] = '{0, 0, 2, 3, 4, 6, 7, 1, 5, 5};

  logic        clk, rst_n, i_start, i_vld, i_last;
  logic [3:0]  i_cls, i_alu_op;
  logic [2:0]  i_f3;
  logic [4:0]  i_rd, i_rs1, i_rs2;
  logic [31:0] i_imm;

  logic        o_rdy, o_wren, o_busy, o_done, o_err;
  logic [9:0]  o_addr;
  logic [31:0] o_wdata;
  logic [1:0]  o_err_code;
  logic [10:0] o_count;

  logic        b_rdy, b_wren, b_busy, b_done, b_err;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata;
  logic [1:0]  b_err_code;
  logic [2:0]  b_count;

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;

  insn_encoder #(.ADDR_W(10), .DEPTH(1024)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_vld(i_vld), .o_rdy(o_rdy),
    .i_last(i_last), .i_cls(i_cls), .i_alu_op(i_alu_op), .i_f3(i_f3), .i_rd(i_rd),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm), .o_imem_wren(o_wren),
    .o_imem_addr(o_addr), .o_imem_wdata(o_wdata), .o_busy(o_busy), .o_done(o_done),
    .o_err(o_err), .o_err_code(o_err_code), .o_count(o_count)
  );

  insn_encoder #(.ADDR_W(2), .DEPTH(4)) dut_small (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_vld(i_vld), .o_rdy(b_rdy),
    .i_last(i_last), .i_cls(i_cls), .i_alu_op(i_alu_op), .i_f3(i_f3), .i_rd(i_rd),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm), .o_imem_wren(b_wren),
    .o_imem_addr(b_addr), .o_imem_wdata(b_wdata), .o_busy(b_busy), .o_done(b_done),
    .o_err(b_err), .o_err_code(b_err_code), .o_count(b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  function automatic bundle_t mk(input int cls, alu, f3, rd, rs1, rs2, imm, input bit last);
    bundle_t b;
    b.cls = cls; b.alu = alu; b.f3 = f3; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2;
    b.imm = 32'(imm); b.last = last;
    return b;
  endfunction

  // Reference: {err_code, word} from the ISA's field rules using integer arithmetic.
  function automatic logic [33:0] ref_enc(input bundle_t b);
    int s, w, code, f7;
    bit shift;
    s = int'(b.imm);
    w = 0;
    code = 0;
    shift = (b.alu >= 7 && b.alu <= 9);
    f7 = (b.alu == 1 || b.alu == 9) ? 32 : 0;
    case (b.cls)
      0: if (b.alu > 9) code = 1;
         else w = (f7 << 25) + (b.rs2 << 20) + (b.rs1 << 15) + (ALU_F3[b.alu] << 12) + (b.rd << 7);
      1: if (b.alu == 1 || b.alu > 9) code = 1;
         else if (shift) begin
           if (s < 0 || s > 31) code = 2;
           else w = (f7 << 25) + (s << 20) + (b.rs1 << 15) + (ALU_F3[b.alu] << 12) + (b.rd << 7);
         end else begin
           if (s < -2048 || s > 2047) code = 2;
           else w = ((s & 4095) << 20) + (b.rs1 << 15) + (ALU_F3[b.alu] << 12) + (b.rd << 7);
         end
      2: if (!(b.f3 inside {0, 1, 2, 4, 5})) code = 1;
         else if (s < -2048 || s > 2047) code = 2;
         else w = ((s & 4095) << 20) + (b.rs1 << 15) + (b.f3 << 12) + (b.rd << 7);
      3: if (b.f3 > 2) code = 1;
         else if (s < -2048 || s > 2047) code = 2;
         else w = (((s >> 5) & 127) << 25) + (b.rs2 << 20) + (b.rs1 << 15) + (b.f3 << 12) + ((s & 31) << 7);
      4: if (b.f3 == 2 || b.f3 == 3) code = 1;
         else if (s < -4096 || s > 4094 || (s & 1) != 0) code = 2;
         else w = (((s >> 12) & 1) << 31) + (((s >> 5) & 63) << 25) + (b.rs2 << 20) + (b.rs1 << 15)
                + (b.f3 << 12) + (((s >> 1) & 15) << 8) + (((s >> 11) & 1) << 7);
      5: if (s < -1048576 || s > 1048574 || (s & 1) != 0) code = 2;
         else w = (((s >> 20) & 1) << 31) + (((s >> 1) & 1023) << 21) + (((s >> 11) & 1) << 20)
                + (((s >> 12) & 255) << 12) + (b.rd << 7);
      6: if (s < -2048 || s > 2047) code = 2;
         else w = ((s & 4095) << 20) + (b.rs1 << 15) + (b.rd << 7);
      7, 8: w = ((s >> 12) << 12) + (b.rd << 7);
      default: code = 1;
    endcase
    if (code == 0) w = w + OPC[b.cls];
    else w = 0;
    return {2'(code), 32'(w)};
  endfunction

  task automatic drive(input bundle_t b);
    i_cls = 4'(b.cls); i_alu_op = 4'(b.alu); i_f3 = 3'(b.f3);
    i_rd = 5'(b.rd); i_rs1 = 5'(b.rs1); i_rs2 = 5'(b.rs2);
    i_imm = b.imm; i_last = b.last; i_vld = 1'b1;
  endtask

  // Called just after a rising edge; leaves the bench just after the following edge.
  task automatic do_start();
    i_vld = 1'b0; i_last = 1'b0; i_start = 1'b1;
    #2;
    checks++; if (o_rdy !== 1'b0) begin errors++; $display("FAIL start_rdy got %b exp 0", o_rdy); end
    @(posedge clk); #1;
    i_start = 1'b0;
    m_ptr = 0;
    #1;
    checks++; if (o_busy !== 1'b1 || o_rdy !== 1'b1) begin errors++; $display("FAIL start_busy busy %b rdy %b exp 1 1", o_busy, o_rdy); end
    checks++; if (o_count !== 11'd0) begin errors++; $display("FAIL start_count got %0d exp 0", o_count); end
    checks++; if (o_err !== 1'b0 || o_err_code !== 2'd0) begin errors++; $display("FAIL start_err err %b code %0d exp 0 0", o_err, o_err_code); end
  endtask

  task automatic send_chk(input bundle_t b, input int exp_code, input logic [31:0] exp_word, input string nm);
    drive(b);
    #2;
    checks++; if (o_rdy !== 1'b1) begin errors++; $display("FAIL %s rdy got %b exp 1", nm, o_rdy); end
    @(posedge clk); #1;
    if (exp_code == 0) begin
      checks++; if (o_wren !== 1'b1) begin errors++; $display("FAIL %s wren got %b exp 1", nm, o_wren); end
      checks++; if (o_addr !== 10'(m_ptr)) begin errors++; $display("FAIL %s addr got %0d exp %0d", nm, o_addr, m_ptr); end
      checks++; if (o_wdata !== exp_word) begin errors++; $display("FAIL %s wdata got %h exp %h", nm, o_wdata, exp_word); end
      m_ptr++;
      checks++; if (o_count !== 11'(m_ptr)) begin errors++; $display("FAIL %s count got %0d exp %0d", nm, o_count, m_ptr); end
      if (b.last) begin
        checks++; if (o_done !== 1'b1 || o_rdy !== 1'b0 || o_busy !== 1'b0) begin
          errors++; $display("FAIL %s done done %b rdy %b busy %b exp 1 0 0", nm, o_done, o_rdy, o_busy); end
      end else begin
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL %s busy got %b exp 1", nm, o_busy); end
      end
    end else begin
      checks++; if (o_wren !== 1'b0) begin errors++; $display("FAIL %s err_wren got %b exp 0", nm, o_wren); end
      checks++; if (o_err !== 1'b1 || o_rdy !== 1'b0) begin errors++; $display("FAIL %s err_state err %b rdy %b exp 1 0", nm, o_err, o_rdy); end
      checks++; if (o_err_code !== 2'(exp_code)) begin errors++; $display("FAIL %s err_code got %0d exp %0d", nm, o_err_code, exp_code); end
      checks++; if (o_count !== 11'(m_ptr)) begin errors++; $display("FAIL %s err_count got %0d exp %0d", nm, o_count, m_ptr); end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_start = 1'b0; i_vld = 1'b0; i_last = 1'b0;
    i_cls = '0; i_alu_op = '0; i_f3 = '0; i_rd = '0; i_rs1 = '0; i_rs2 = '0; i_imm = '0;
    #12;
    checks++; if (o_rdy !== 1'b0 || o_wren !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_err !== 1'b0) begin
      errors++; $display("FAIL reset_flags rdy %b wren %b busy %b done %b err %b exp 0", o_rdy, o_wren, o_busy, o_done, o_err); end
    checks++; if (o_addr !== 10'd0 || o_wdata !== 32'd0 || o_err_code !== 2'd0 || o_count !== 11'd0) begin
      errors++; $display("FAIL reset_data addr %0d wdata %h code %0d count %0d exp 0", o_addr, o_wdata, o_err_code, o_count); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (o_busy !== 1'b0 || o_rdy !== 1'b0) begin errors++; $display("FAIL idle_hold busy %b rdy %b exp 0 0", o_busy, o_rdy); end
  endtask

  task automatic test_basic();
    do_start();
    send_chk(mk(0, 0, 0, 1, 2, 3, 0, 0), 0, 32'h003100B3, "add");
    i_vld = 1'b0;
    @(posedge clk); #1;
    checks++; if (o_wren !== 1'b0) begin errors++; $display("FAIL wren_pulse got %b exp 0", o_wren); end
    checks++; if (o_count !== 11'd1) begin errors++; $display("FAIL idle_count got %0d exp 1", o_count); end
  endtask

  task automatic test_back_to_back();
    send_chk(mk(0, 1, 0, 1, 2, 3, 0, 0), 0, 32'h403100B3, "sub");
    send_chk(mk(1, 0, 0, 5, 0, 0, -1, 0), 0, 32'hFFF00293, "addi_m1");
    send_chk(mk(1, 9, 0, 3, 4, 0, 5, 0), 0, 32'h40525193, "srai");
    send_chk(mk(4, 0, 0, 0, 1, 2, 8, 0), 0, 32'h00208463, "beq");
    send_chk(mk(5, 0, 0, 1, 0, 0, 2048, 0), 0, 32'h001000EF, "jal");
    send_chk(mk(7, 0, 0, 10, 0, 0, 32'h12345000, 1), 0, 32'h12345537, "lui_last");
    i_vld = 1'b0;
    @(posedge clk); #1;
    checks++; if (o_done !== 1'b1 || o_rdy !== 1'b0 || o_wren !== 1'b0 || o_count !== 11'd7) begin
      errors++; $display("FAIL done_hold done %b rdy %b wren %b count %0d exp 1 0 0 7", o_done, o_rdy, o_wren, o_count); end
  endtask

  task automatic test_illegal();
    bundle_t bl [12];
    int      cl [12];
    bl[0]  = mk(1, 1, 0, 1, 1, 0, 4, 0);          cl[0]  = 1;
    bl[1]  = mk(1, 0, 0, 1, 1, 0, 2048, 0);       cl[1]  = 2;
    bl[2]  = mk(4, 0, 0, 0, 1, 2, 7, 0);          cl[2]  = 2;
    bl[3]  = mk(9, 0, 0, 1, 1, 1, 0, 0);          cl[3]  = 1;
    bl[4]  = mk(2, 0, 3, 1, 1, 0, 0, 0);          cl[4]  = 1;
    bl[5]  = mk(3, 0, 3, 0, 1, 2, 0, 0);          cl[5]  = 1;
    bl[6]  = mk(4, 0, 2, 0, 1, 2, 8, 0);          cl[6]  = 1;
    bl[7]  = mk(0, 10, 0, 1, 2, 3, 0, 0);         cl[7]  = 1;
    bl[8]  = mk(1, 7, 0, 1, 1, 0, 32, 0);         cl[8]  = 2;
    bl[9]  = mk(5, 0, 0, 1, 0, 0, 1048576, 0);    cl[9]  = 2;
    bl[10] = mk(6, 0, 0, 1, 1, 0, -2049, 0);      cl[10] = 2;
    bl[11] = mk(4, 0, 0, 0, 1, 2, 4096, 0);       cl[11] = 2;
    for (int k = 0; k < 12; k++) begin
      do_start();
      send_chk(mk(1, 0, 0, 2, 2, 0, 1, 0), 0, 32'h00110113, "pre_ok");
      send_chk(bl[k], cl[k], 32'd0, $sformatf("illegal%0d", k));
    end
    i_vld = 1'b0;
    @(posedge clk); #1;
    checks++; if (o_err !== 1'b1 || o_count !== 11'd1) begin errors++; $display("FAIL err_hold err %b count %0d exp 1 1", o_err, o_count); end
  endtask

  task automatic test_boundary();
    bundle_t bl [8];
    logic [33:0] r;
    bl[0] = mk(1, 0, 0, 3, 4, 0, -2048, 0);
    bl[1] = mk(1, 6, 0, 3, 4, 0, 2047, 0);
    bl[2] = mk(4, 5, 0, 0, 7, 9, -4096, 0);
    bl[3] = mk(4, 0, 7, 0, 7, 9, 4094, 0);
    bl[4] = mk(5, 0, 0, 31, 0, 0, -1048576, 0);
    bl[5] = mk(5, 0, 0, 31, 0, 0, 1048574, 0);
    bl[6] = mk(1, 8, 0, 3, 4, 0, 31, 0);
    bl[7] = mk(8, 0, 0, 17, 0, 0, -4096, 1);
    do_start();
    for (int k = 0; k < 8; k++) begin
      r = ref_enc(bl[k]);
      send_chk(bl[k], int'(r[33:32]), r[31:0], $sformatf("bound%0d", k));
    end
    i_vld = 1'b0;
  endtask

  task automatic test_overflow();
    do_start();
    for (int k = 0; k < 5; k++) begin
      drive(mk(1, 0, 0, k + 1, 0, 0, k, 0));
      @(posedge clk); #1;
      if (k < 4) begin
        checks++; if (b_wren !== 1'b1 || b_addr !== 2'(k) || b_count !== 3'(k + 1)) begin
          errors++; $display("FAIL ovf_write%0d wren %b addr %0d count %0d exp 1 %0d %0d", k, b_wren, b_addr, b_count, k, k + 1); end
      end else begin
        checks++; if (b_wren !== 1'b0 || b_err !== 1'b1 || b_err_code !== 2'd3 || b_count !== 3'd4) begin
          errors++; $display("FAIL ovf_err wren %b err %b code %0d count %0d exp 0 1 3 4", b_wren, b_err, b_err_code, b_count); end
      end
    end
    i_vld = 1'b0;
  endtask

  task automatic test_random();
    bundle_t b;
    logic [33:0] r;
    int s;
    do_start();
    for (int n = 0; n < 300; n++) begin
      b.cls = int'($urandom_range(0, 9));
      b.alu = int'($urandom_range(0, 11));
      b.f3  = int'($urandom_range(0, 7));
      b.rd  = int'($urandom_range(0, 31));
      b.rs1 = int'($urandom_range(0, 31));
      b.rs2 = int'($urandom_range(0, 31));
      case ($urandom_range(0, 3))
        0:       s = int'($urandom_range(0, 4200)) - 2100;
        1:       s = int'($urandom_range(0, 40));
        2:       s = int'($urandom_range(0, 2200000)) - 1100000;
        default: s = int'($urandom);
      endcase
      if ($urandom_range(0, 3) != 0) s = s & ~1;
      b.imm  = 32'(s);
      b.last = ($urandom_range(0, 11) == 0);
      r = ref_enc(b);
      send_chk(b, int'(r[33:32]), r[31:0], $sformatf("rand%0d", n));
      if (r[33:32] != 2'd0 || b.last) do_start();
    end
    i_vld = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_start();
    drive(mk(0, 0, 0, 1, 2, 3, 0, 0));
    @(posedge clk); #1;
    checks++; if (o_wren !== 1'b1) begin errors++; $display("FAIL mid_pre_wren got %b exp 1", o_wren); end
    rst_n = 1'b0;
    #1;
    checks++; if (o_wren !== 1'b0 || b_wren !== 1'b0 || o_rdy !== 1'b0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset_flags wren %b bwren %b rdy %b busy %b exp 0", o_wren, b_wren, o_rdy, o_busy); end
    checks++; if (o_addr !== 10'd0 || o_wdata !== 32'd0 || o_count !== 11'd0 || o_err_code !== 2'd0) begin
      errors++; $display("FAIL mid_reset_data addr %0d wdata %h count %0d code %0d exp 0", o_addr, o_wdata, o_count, o_err_code); end
    i_vld = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_illegal();
    test_boundary();
    test_overflow();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/insn_encoder.md
Name: insn_encoder

Overview:
- Program-loader block: accepts RV32I instructions as decoded fields (class, alu_op, func3, rd/rs1/rs2, immediate), packs each into a 32-bit machine word, and writes it sequentially into instruction memory.
- Inverse of the control-unit decoding; uses the same 4-bit alu_op code.
- Sits between the boot/test sequencer and the IMEM write port. Validates field combinations and flags illegal ones instead of writing them.

Parameters:
- ADDR_W, 10, IMEM word-address width.
- DEPTH, 1024, max words loadable (≤ 2^ADDR_W).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  begin a load session; clears pointer and flags.
- i_vld  in  1  field bundle valid.
- o_rdy  out  1  encoder accepts bundle.
- i_last  in  1  bundle is final instruction of program.
- i_cls  in  4  class: 0 R, 1 IMM, 2 LD, 3 S, 4 B, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC; others illegal.
- i_alu_op  in  4  ADD 0000, SUB 0001, SLT 0010, SLTU 0011, XOR 0100, OR 0101, AND 0110, SLL 0111, SRL 1000, SRA 1001 (R/IMM only).
- i_f3  in  3  func3 for LD/S/B.
- i_rd, i_rs1, i_rs2  in  5 each  register indices.
- i_imm  in  32  signed immediate; byte offset for B/JAL; U-classes use i_imm[31:12].
- o_imem_wren  out  1  write strobe.
- o_imem_addr  out  ADDR_W  word address.
- o_imem_wdata  out  32  encoded word.
- o_busy  out  1  state LOAD.
- o_done  out  1  state DONE.
- o_err  out  1  state ERR.
- o_err_code  out  2  1 illegal field, 2 imm out of range, 3 overflow.
- o_count  out  ADDR_W+1  words written.

Behaviour:
- Async reset: state IDLE, all outputs 0, pointer 0.
- FSM states: IDLE, LOAD, DONE, ERR.
  - Any state with i_start=1 → LOAD. Pointer, o_count, o_err_code are cleared. o_rdy=0 that cycle.
  - LOAD: o_rdy=1. A bundle is accepted on i_vld & o_rdy.
- Legal accept:
  - Next edge registers o_imem_wdata and o_imem_addr=pointer, and pulses o_imem_wren for exactly 1 cycle.
  - Pointer and o_count increment.
  - Throughput is 1 word/cycle; latency is 1 cycle from accept to write.
- Accept with i_last: word is written, then state → DONE.
- Illegal accept: no write, state → ERR, o_err_code set, pointer held. Illegal conditions:
  - i_cls > 8.
  - R with alu_op > 1001.
  - IMM with alu_op = 0001 or > 1001.
  - LD f3 ∉ {000,001,010,100,101}.
  - S f3 ∉ {000,001,010}.
  - B f3 ∈ {010,011}.
- Immediate range checks (code 2):
  - IMM/LD/S/JALR: imm ∈ [-2048, 2047].
  - IMM shifts: imm ∈ [0, 31].
  - B: [-4096, 4094], bit0 = 0.
  - JAL: [-2^20, 2^20-2], bit0 = 0.
  - U classes: no check.
- Overflow (code 3): accept while pointer == DEPTH → ERR, no write.
- Encoding:
  - Standard RV32I field placement and opcodes.
  - R: func7 = 0100000 for SUB/SRA, else 0.
  - IMM shifts: imm[11:5] = 0100000 for SRA.
  - JALR: func3 = 000.
  - Unused fields are zero.
- DONE/ERR hold, with o_rdy=0, until i_start or reset.
- A write pending from the previous accept still completes on the cycle i_start is asserted; pointer clear takes effect after that.
- Reset mid-write: wren drops immediately (async).

Test Plan:
- start; add rd1,rs1=2,rs2=3 → wdata 0x003100B3 at addr 0, wren 1 cycle.
- Back-to-back: sub (same regs), addi rd5 rs1 0 imm -1 → 0x403100B3 @1, 0xFFF00293 @2, consecutive cycles, o_count=3.
- srai rd3 rs1 4 imm 5, beq rs1 1 rs2 2 imm 8, jal rd1 imm 2048, lui rd10 imm 0x12345000 with i_last on the last → 0x40525193, 0x00208463, 0x001000EF, 0x12345537; o_done=1, o_rdy=0.
- IMM with alu_op 0001 → o_err=1, code 1, no wren, o_count unchanged. Then i_start → LOAD, count 0.
- addi imm 2048 → code 2. B imm 7 → code 2.
- DEPTH=4: 5 legal bundles → 4 writes, then ERR code 3. Assert i_rst_n low mid-stream → all outputs 0 asynchronously.
